sad_result_monitor: RTL and testbench

- Consumer end of the datapath result interface: watches the v0/v1 result registers every cycle.
- Detects each change of the {v0, v1} pair, queues the new pair in a small show-ahead FIFO, and serves it to a downstream reader (UART/display/checker) over a valid/ready handshake.
- Flags completion once results stay stable for a set number of cycles.
- Sits beside the top-level datapath, on the same clock and reset.

---
 rtl/sad_result_monitor.sv | 128 ++++++++++++
 tb/tb_sad_result_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_result_monitor.sv
// rtl/sad_result_monitor.sv - change-detecting v0/v1 result monitor with show-ahead FIFO and stable-done flag
// Optional MON_DROP_COUNT_EN adds a saturating drop_count output.
module sad_result_monitor #(
  parameter int DEPTH         = 8,
  parameter int STABLE_CYCLES = 64,
  parameter int CW            = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   v0_in,
  input  logic [31:0]   v1_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_v0,
  output logic [31:0]   out_v1,
  output logic [CW-1:0] count,
  output logic          overflow,
`ifdef MON_DROP_COUNT_EN
  output logic          done,
  output logic [15:0]   drop_count
`else
  output logic          done
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic [31:0]   r_prev_v0;
  logic [31:0]   r_prev_v1;
  logic [31:0]   r_mem_v0 [DEPTH];
  logic [31:0]   r_mem_v1 [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [SW-1:0] r_stable;
  logic          r_seen;
  logic          r_done;

  logic          w_chg;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [SW-1:0] w_stable_nxt;
  logic          w_seen_nxt;

  assign w_chg  = ({v0_in, v1_in} != {r_prev_v0, r_prev_v1});
  assign w_pop  = out_valid & out_ready;
  assign w_full = (r_count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push = w_chg & (~w_full | w_pop);
  assign w_drop = w_chg & w_full & ~w_pop;

  always_comb begin
    w_stable_nxt = r_stable;
    w_seen_nxt   = r_seen | w_chg;
    if (w_chg) begin
      w_stable_nxt = '0;
    end else if (r_stable != SW'(STABLE_CYCLES)) begin
      w_stable_nxt = r_stable + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_v0  <= '0;
      r_prev_v1  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_stable   <= '0;
      r_seen     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_v0[i] <= '0;
        r_mem_v1[i] <= '0;
      end
    end else begin
      r_prev_v0 <= v0_in;
      r_prev_v1 <= v1_in;
      if (w_push) begin
        r_mem_v0[r_wr_ptr] <= v0_in;
        r_mem_v1[r_wr_ptr] <= v1_in;
        r_wr_ptr           <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_stable <= w_stable_nxt;
      r_seen   <= w_seen_nxt;
      // Evaluated on next-state values so done rises on the edge the counter saturates.
      r_done   <= w_seen_nxt & (w_stable_nxt == SW'(STABLE_CYCLES));
    end
  end

`ifdef MON_DROP_COUNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign out_valid = (r_count != '0);
  assign out_v0    = r_mem_v0[r_rd_ptr];
  assign out_v1    = r_mem_v1[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign done      = r_done;

endmodule

// File: tb/tb_sad_result_monitor.sv
// tb/tb_sad_result_monitor.sv - directed self-checking bench for sad_result_monitor
// Build with MON_DROP_COUNT_EN defined to also check drop_count.
module tb_sad_result_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] v0_in = '0;
  logic [31:0] v1_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_v0;
  logic [31:0] out_v1;
  logic [3:0]  count;
  logic        overflow;
  logic        done;
`ifdef MON_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] rx[$];

  always #5 clk = ~clk;

  sad_result_monitor #(.DEPTH(8), .STABLE_CYCLES(64), .CW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .v0_in     (v0_in),
    .v1_in     (v1_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_v0    (out_v0),
    .out_v1    (out_v1),
    .count     (count),
    .overflow  (overflow),
`ifdef MON_DROP_COUNT_EN
    .done      (done),
    .drop_count(drop_count)
`else
    .done      (done)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b0; v0_in = '0; v1_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_pair(input int a, input int b);
    v0_in = a; v1_in = b;
  endtask

  // Pops with out_ready held high for n cycles, recording each accepted head.
  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (out_valid) rx.push_back({out_v0, out_v1});
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b count=%0d ovf=%b done=%b expected 0 0 0 0", out_valid, count, overflow, done);
    end
    checks++;
    if (out_v0 !== 32'd0 || out_v1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: v0=%0h v1=%0h expected 0 0", out_v0, out_v1);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 4'd0 || done !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc%0d: valid=%b count=%0d done=%b ovf=%b expected 0 0 0 0", i, out_valid, count, done, overflow);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_pair(5, 3);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_v0 !== 32'd5 || out_v1 !== 32'd3 || count !== 4'd1) begin
      errors++;
      $display("FAIL single_push: valid=%b v0=%0d v1=%0d count=%0d expected 1 5 3 1", out_valid, out_v0, out_v1, count);
    end
    for (int i = 0; i < 63; i++) tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_early: done=%b expected 0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%b expected 1", done);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: count=%0d valid=%b done=%b expected 0 0 1", count, out_valid, done);
    end
  endtask

  task automatic test_ordering();
    logic [63:0] exp_q[$];
    exp_q = '{ {32'd1, 32'd1}, {32'd2, 32'd1}, {32'd2, 32'd2}, {32'd3, 32'd2} };
    do_reset();
    rx.delete();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        v0_in = exp_q[i][63:32];
        v1_in = exp_q[i][31:0];
      end
      out_ready = (i >= 2);
      if (out_valid && out_ready) rx.push_back({out_v0, out_v1});
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (rx.size() != 4 || count !== 4'd0) begin
      errors++;
      $display("FAIL order_count: received=%0d count=%0d expected 4 0", rx.size(), count);
    end
    for (int i = 0; i < 4 && i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL order_entry%0d: got %h expected %h", i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      set_pair(k, k);
      tick();
      if (k == 8) begin
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full: count=%0d ovf=%b expected 8 0", count, overflow);
        end
      end
    end
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: count=%0d ovf=%b expected 8 1", count, overflow);
    end
`ifdef MON_DROP_COUNT_EN
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL ovf_drop_count: got %0d expected 1", drop_count);
    end
`endif
    rx.delete();
    drain(12);
    checks++;
    if (rx.size() != 8 || overflow !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL ovf_drain: received=%0d ovf=%b count=%0d expected 8 1 0", rx.size(), overflow, count);
    end
    for (int i = 0; i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== {32'(i + 1), 32'(i + 1)}) begin
        errors++;
        $display("FAIL ovf_entry%0d: got %h expected pair %0d", i, rx[i], i + 1);
      end
    end
  endtask

  task automatic test_full_simultaneous();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      set_pair(k, k);
      tick();
    end
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fs_fill: count=%0d ovf=%b expected 8 0", count, overflow);
    end
    rx.delete();
    set_pair(20, 20);
    out_ready = 1'b1;
    if (out_valid) rx.push_back({out_v0, out_v1});
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fs_pushpop: count=%0d ovf=%b expected 8 0", count, overflow);
    end
    drain(12);
    checks++;
    if (rx.size() != 9) begin
      errors++;
      $display("FAIL fs_total: received=%0d expected 9", rx.size());
    end else begin
      checks++;
      if (rx[0] !== {32'd1, 32'd1} || rx[7] !== {32'd8, 32'd8} || rx[8] !== {32'd20, 32'd20}) begin
        errors++;
        $display("FAIL fs_order: first=%h eighth=%h last=%h expected pairs 1 8 20", rx[0], rx[7], rx[8]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_pair(k, k);
      tick();
    end
    for (int i = 0; i < 64; i++) tick();
    checks++;
    if (count !== 4'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: count=%0d done=%b expected 3 1", count, done);
    end
    rst = 1'b1;
    set_pair(4, 4);
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d valid=%b done=%b ovf=%b expected 0 0 0 0", count, out_valid, done, overflow);
    end
    set_pair(0, 0);
    tick(); tick();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_nopush: count=%0d valid=%b expected 0 0", count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_ordering();
    test_overflow();
    test_full_simultaneous();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
